// File: rtl/counter_job_ctrl_pkg.sv
// Shared types and constants for the counter job controller.
//   STEP_W    : width of the shared counter datapath and of a job's step value
//   JOB_LEN_W : width of the run-length field held in a latched job
//   JOB_ID_W  : id field width, wide enough for the largest supported NREQ (8)
//   state_t   : controller states
//   job_t     : job fields captured at grant time
package counter_job_ctrl_pkg;

  localparam int STEP_W    = 4;
  localparam int JOB_LEN_W = 8;
  localparam int JOB_ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [JOB_ID_W-1:0]  id;
    logic [STEP_W-1:0]    step;
    logic [JOB_LEN_W-1:0] len;
  } job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : per-requester request bits
//   pointer : highest-priority requester index (register lives in the parent)
//   enable  : when low, no grant is issued
//   gnt     : one-hot grant to the first set request at or after pointer, wrapping
//   id      : binary index of the winner (meaningful when gnt != 0)
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  pointer,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);

  // Requests at or above the pointer take precedence; if there are none the
  // search wraps, which is the same as taking the lowest set bit of req.
  logic [NREQ-1:0] upper;
  logic [NREQ-1:0] pick;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_upper
      assign upper[gi] = req[gi] && (IDW'(gi) >= pointer);
    end
  endgenerate

  assign pick = (|upper) ? upper : req;

  always_comb begin
    gnt = '0;
    id  = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        id = IDW'(i);
      end
    end
    if (enable && (|req)) begin
      gnt[id] = 1'b1;
    end
  end

endmodule

// File: rtl/counter_job_ctrl.sv
// Shares one 4-bit accumulating counter between NREQ requesters.
// A granted job clears the counter, drives its increment input with the
// job's step for len cycles, then reports the final count and flags a
// mismatch against an internally accumulated expected value.
//   clk, reset     : clock, asynchronous active-high reset
//   req            : per-requester job request (level, held until gnt)
//   step, len      : packed per-requester step (4 bits) and run length (LEN_W)
//   gnt            : one-hot single-cycle grant, fields captured that cycle
//   busy           : high whenever a job is being processed
//   ctr_reset      : counter synchronous reset (also follows reset)
//   ctr_count_in   : counter increment input
//   ctr_count_out  : counter current value
//   done, done_id  : single-cycle completion pulse and the job's requester id
//   result, err    : final count and expected-value mismatch flag (with done)
// LEN_W must not exceed JOB_LEN_W, the length field held in a latched job.
module counter_job_ctrl
  import counter_job_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int LEN_W = JOB_LEN_W,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*STEP_W-1:0]  step,
  input  logic [NREQ*LEN_W-1:0]   len,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    ctr_reset,
  output logic [STEP_W-1:0]       ctr_count_in,
  input  logic [STEP_W-1:0]       ctr_count_out,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [STEP_W-1:0]       result,
  output logic                    err
);

  state_t            state_reg;
  logic [IDW-1:0]    ptr_reg;
  job_t              job_reg;
  logic [LEN_W-1:0]  rem_reg;
  logic [STEP_W-1:0] exp_reg;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDW-1:0]    arb_id;
  logic              arb_en;

  logic [STEP_W-1:0] step_arr [NREQ];
  logic [LEN_W-1:0]  len_arr  [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign step_arr[gi] = step[gi*STEP_W +: STEP_W];
      assign len_arr[gi]  = len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Reset is folded into the enable so gnt stays low while reset is held,
  // even though the grant path is combinational from req.
  assign arb_en = (state_reg == IDLE) && !reset;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req),
    .pointer (ptr_reg),
    .enable  (arb_en),
    .gnt     (arb_gnt),
    .id      (arb_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      job_reg   <= '0;
      rem_reg   <= '0;
      exp_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|arb_gnt) begin
            job_reg.id   <= JOB_ID_W'(arb_id);
            job_reg.step <= step_arr[arb_id];
            job_reg.len  <= JOB_LEN_W'(len_arr[arb_id]);
            ptr_reg      <= (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
            state_reg    <= CLEAR;
          end
        end
        CLEAR: begin
          rem_reg   <= LEN_W'(job_reg.len);
          exp_reg   <= '0;
          state_reg <= (job_reg.len != '0) ? RUN : DONE;
        end
        RUN: begin
          // exp wraps mod 16 exactly like the 4-bit counter it shadows.
          exp_reg <= exp_reg + job_reg.step;
          rem_reg <= rem_reg - 1'b1;
          if (rem_reg == LEN_W'(1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode only the state register, so they are glitch-free apart
  // from gnt (intentionally same-cycle) and ctr_reset (follows reset).
  assign gnt          = arb_gnt;
  assign busy         = (state_reg != IDLE);
  assign ctr_reset    = reset | (state_reg == CLEAR);
  assign ctr_count_in = (state_reg == RUN) ? job_reg.step : '0;
  assign done         = (state_reg == DONE);
  assign done_id      = done ? IDW'(job_reg.id) : '0;
  assign result       = done ? ctr_count_out : '0;
  assign err          = done && (ctr_count_out != exp_reg);

endmodule

// File: tb/tb_counter_job_ctrl.sv
module tb_counter_job_ctrl;
  import counter_job_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int LEN_W = 8;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*4-1:0]      step;
  logic [NREQ*LEN_W-1:0]  len;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   ctr_reset;
  logic [3:0]             ctr_count_in;
  logic [3:0]             ctr_count_out;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic [3:0]             result;
  logic                   err;

  counter_job_ctrl #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .step          (step),
    .len           (len),
    .gnt           (gnt),
    .busy          (busy),
    .ctr_reset     (ctr_reset),
    .ctr_count_in  (ctr_count_in),
    .ctr_count_out (ctr_count_out),
    .done          (done),
    .done_id       (done_id),
    .result        (result),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Counter instance model: 4-bit accumulator with synchronous reset.
  // 'stuck' forces its output to 0 to emulate a broken counter.
  logic [3:0] cnt_reg;
  logic       stuck = 1'b0;
  always @(posedge clk) begin
    if (ctr_reset) cnt_reg <= 4'd0;
    else           cnt_reg <= cnt_reg + ctr_count_in;
  end
  assign ctr_count_out = stuck ? 4'd0 : cnt_reg;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: a job timeline relative to its grant cycle.
  int m_active = 0, m_g = 0, m_len = 0, m_step = 0, m_id = 0, m_ptr = 0;
  int m_gnt_id = -1;

  // Observations for scenario-level checks.
  int gnt_log[$];
  int gnt_cycs[$];
  int last_gnt_cyc = 0, last_done_cyc = 0;
  int last_done_id = 0, last_result = 0, last_err = 0;
  int done_count = 0, rst_pulses = 0;
  bit auto_drop = 1'b1;
  bit rnd_mode  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Sample at the falling edge, predict, compare.
  task automatic eval();
    logic [NREQ-1:0] e_gnt;
    logic       e_busy, e_rst, e_done, e_err;
    logic [3:0] e_cin, e_res;
    int d, w, ideal;
    @(negedge clk);
    cyc++;
    e_gnt = '0; e_busy = 0; e_rst = 0; e_done = 0; e_err = 0; e_cin = 0; e_res = 0;
    m_gnt_id = -1;
    if (reset) begin
      m_active = 0;
      m_ptr    = 0;
      e_rst    = 1;
    end else if (!m_active) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) begin
        e_gnt    = NREQ'(1) << w;
        m_id     = w;
        m_step   = int'(step[4*w +: 4]);
        m_len    = int'(len[LEN_W*w +: LEN_W]);
        m_g      = cyc;
        m_active = 1;
        m_ptr    = (w + 1) % NREQ;
        m_gnt_id = w;
      end
    end else begin
      e_busy = 1;
      d = cyc - m_g;
      if (d == 1) e_rst = 1;
      else if (d <= 1 + m_len) e_cin = 4'(m_step);
      else begin
        ideal    = (m_step * m_len) % 16;
        e_done   = 1;
        e_res    = stuck ? 4'd0 : 4'(ideal);
        e_err    = (int'(e_res) != ideal);
        m_active = 0;
      end
    end

    check("gnt", 32'(gnt), 32'(e_gnt));
    check("busy", 32'(busy), 32'(e_busy));
    check("ctr_reset", 32'(ctr_reset), 32'(e_rst));
    check("ctr_count_in", 32'(ctr_count_in), 32'(e_cin));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(e_err));
    if (e_done) begin
      check("done_id", 32'(done_id), 32'(m_id));
      check("result", 32'(result), 32'(e_res));
    end

    if (ctr_reset) rst_pulses++;
    if (|gnt) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
      gnt_cycs.push_back(cyc);
      last_gnt_cyc = cyc;
    end
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
      last_done_id  = int'(done_id);
      last_result   = int'(result);
      last_err      = int'(err);
      $display("job done: cycle=%0d id=%0d result=%0d err=%0d", cyc, done_id, result, err);
    end
  endtask

  // Advance to just after the rising edge and update stimulus.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rnd_mode) begin
      if (auto_drop && m_gnt_id >= 0) req[m_gnt_id] = 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt_id == i) req[i] = 1'b0;
        else if (req[i]) begin
          if ($urandom_range(0, 29) == 0) req[i] = 1'b0;
        end else begin
          // Fields of idle requesters churn freely, including during other jobs.
          step[4*i +: 4] = 4'($urandom);
          len[LEN_W*i +: LEN_W] = ($urandom_range(0, 3) == 0) ?
                                  LEN_W'($urandom_range(0, 20)) : LEN_W'($urandom_range(0, 4));
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
      if (reset) begin
        if ($urandom_range(0, 1) == 0) reset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      eval();
      tick();
    end
  endtask

  initial begin
    int dc;
    reset = 1'b1;
    req   = '0;
    step  = '0;
    len   = '0;

    // Reset state.
    run(3);
    reset = 1'b0;
    run(2);

    // Single job on requester 2: step 3, len 5.
    step[11:8] = 4'd3; len[23:16] = 8'd5; req = 4'b0100;
    run(12);
    check("p1_latency", 32'(last_done_cyc - last_gnt_cyc), 32'd7);
    check("p1_id", 32'(last_done_id), 32'd2);
    check("p1_result", 32'(last_result), 32'd15);
    check("p1_err", 32'(last_err), 32'd0);

    // Wrap: requester 0, step 15, len 3 -> 45 mod 16.
    step[3:0] = 4'd15; len[7:0] = 8'd3; req = 4'b0001;
    run(8);
    check("wrap_result", 32'(last_result), 32'd13);
    check("wrap_err", 32'(last_err), 32'd0);

    // len=0 on requester 1.
    rst_pulses = 0;
    step[7:4] = 4'd9; len[15:8] = 8'd0; req = 4'b0010;
    run(6);
    check("len0_latency", 32'(last_done_cyc - last_gnt_cyc), 32'd2);
    check("len0_result", 32'(last_result), 32'd0);
    check("len0_rst_pulses", 32'(rst_pulses), 32'd1);

    // Reset four cycles into a len=10 job on requester 2.
    step[11:8] = 4'd1; len[23:16] = 8'd10; req = 4'b0100;
    dc = done_count;
    eval(); tick();
    run(3);
    #1 reset = 1'b1;
    req = 4'b1111;
    len = {8'd1, 8'd1, 8'd1, 8'd1};
    step = 16'h7531;
    run(3);
    check("rst_no_done", 32'(done_count), 32'(dc));
    reset = 1'b0;

    // Round-robin with all requests held, len=1.
    auto_drop = 1'b0;
    gnt_log.delete();
    gnt_cycs.delete();
    run(20);
    req = '0;
    auto_drop = 1'b1;
    run(4);
    check("rr_count", 32'(gnt_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++)
      check("rr_order", 32'(gnt_log[k]), 32'(k % NREQ));
    for (int k = 1; k < 5 && k < gnt_cycs.size(); k++)
      check("rr_spacing", 32'(gnt_cycs[k] - gnt_cycs[k-1]), 32'd4);

    // Broken counter: output stuck at 0 during step 2, len 4 on requester 1.
    stuck = 1'b1;
    step[7:4] = 4'd2; len[15:8] = 8'd4; req = 4'b0010;
    run(10);
    check("stuck_result", 32'(last_result), 32'd0);
    check("stuck_err", 32'(last_err), 32'd1);
    stuck = 1'b0;

    // Randomized traffic with occasional asynchronous resets.
    rnd_mode = 1'b1;
    run(1500);
    rnd_mode = 1'b0;
    reset = 1'b0;
    req = '0;
    run(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
